// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, {addr,rw}, ACK check, one data byte, STOP.
// Open-drain outputs: *_oe=1 pulls the line low.
module i2c_master_byte #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, RNACK, STOP
    } state_t;

    state_t        state;
    logic [1:0]    q;
    logic [CW-1:0] cnt;
    logic [2:0]    bcnt;
    logic [7:0]    sh;
    logic [7:0]    wdata_r;
    logic          rw_r;
    logic          sda_s1;
    logic          sda_s2;
    logic          tick;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            q       <= '0;
            cnt     <= '0;
            bcnt    <= '0;
            sh      <= '0;
            wdata_r <= '0;
            rw_r    <= 1'b0;
            sda_s1  <= 1'b1;
            sda_s2  <= 1'b1;
            rdata   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
        end else begin
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            done   <= 1'b0;
            if (!busy) begin
                if (start) begin
                    state   <= START;
                    busy    <= 1'b1;
                    ack_err <= 1'b0;
                    sh      <= {dev_addr, rw};
                    rw_r    <= rw;
                    wdata_r <= wdata;
                    q       <= '0;
                    cnt     <= '0;
                    bcnt    <= '0;
                end
            end else if (!tick) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
                q   <= q + 2'd1;
                // Each tick moves into quarter q+1; outputs are set for that quarter.
                unique case (q)
                    2'd0: scl_oe <= 1'b0;
                    2'd1: begin
                        if (state == START)
                            sda_oe <= 1'b1;
                        else if (state == STOP)
                            sda_oe <= 1'b0;
                        else if (state == RDATA)
                            rdata <= {rdata[6:0], sda_s2};
                        else if ((state == AACK || state == WACK) && sda_s2)
                            ack_err <= 1'b1;
                    end
                    2'd2: if (state != STOP) scl_oe <= 1'b1;
                    2'd3: begin
                        unique case (state)
                            START: begin
                                state  <= ADDR;
                                bcnt   <= '0;
                                sda_oe <= ~sh[7];
                            end
                            ADDR, WDATA: begin
                                if (bcnt == 3'd7) begin
                                    state  <= (state == ADDR) ? AACK : WACK;
                                    sda_oe <= 1'b0;
                                end else begin
                                    bcnt   <= bcnt + 3'd1;
                                    sh     <= {sh[6:0], 1'b0};
                                    sda_oe <= ~sh[6];
                                end
                            end
                            AACK: begin
                                bcnt <= '0;
                                if (ack_err) begin
                                    state  <= STOP;
                                    sda_oe <= 1'b1;
                                end else if (rw_r) begin
                                    state <= RDATA;
                                end else begin
                                    state  <= WDATA;
                                    sh     <= wdata_r;
                                    sda_oe <= ~wdata_r[7];
                                end
                            end
                            WACK, RNACK: begin
                                state  <= STOP;
                                sda_oe <= 1'b1;
                            end
                            RDATA: begin
                                if (bcnt == 3'd7)
                                    state <= RNACK;
                                else
                                    bcnt <= bcnt + 3'd1;
                            end
                            STOP: begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                            default: begin
                                state  <= IDLE;
                                busy   <= 1'b0;
                                scl_oe <= 1'b0;
                                sda_oe <= 1'b0;
                            end
                        endcase
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: table of transactions against a behavioural
// I2C slave, plus mid-transfer start and mid-transfer reset sequences.
module tb_i2c_master_byte;

    localparam int CD = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [6:0] dev_addr;
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_line;
    logic       pull = 1'b0;

    assign sda_line = ~(sda_oe | pull);

    i2c_master_byte #(.CLK_DIV(CD)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .dev_addr (dev_addr),
        .rw       (rw),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .sda_in   (sda_line)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // slave configuration, written by the stimulus process only
    logic       ack_addr = 1'b1;
    logic       ack_data = 1'b1;
    logic [7:0] tx = 8'h00;
    int         clr_seq = 0;

    // slave observations, written by the model process only
    int         clr_seen = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         glitch_cnt = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic [7:0] rx_addr = 8'h00;
    logic [7:0] rx_data = 8'h00;
    logic       mnack = 1'b0;

    initial begin : model
        logic       prev_scl;
        logic       prev_sda;
        logic       scl;
        logic       sda;
        logic       in_frame;
        logic       xmit;
        logic       is_read;
        logic [7:0] shreg;
        int         bitn;
        int         byte_idx;
        prev_scl = 1'b1;
        prev_sda = 1'b1;
        in_frame = 1'b0;
        xmit     = 1'b0;
        is_read  = 1'b0;
        shreg    = 8'h00;
        bitn     = 0;
        byte_idx = 0;
        forever begin
            @(negedge clk);
            scl = ~scl_oe;
            sda = sda_line;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (clr_seq != clr_seen) begin
                clr_seen   = clr_seq;
                start_cnt  = 0;
                stop_cnt   = 0;
                glitch_cnt = 0;
                rx_addr    = 8'h00;
                rx_data    = 8'h00;
                mnack      = 1'b0;
                in_frame   = 1'b0;
                xmit       = 1'b0;
                bitn       = 0;
                byte_idx   = 0;
                pull       = 1'b0;
            end else if (prev_scl && scl && prev_sda != sda) begin
                glitch_cnt++;
                pull = 1'b0;
                if (!sda) begin
                    start_cnt++;
                    in_frame = 1'b1;
                    bitn     = 0;
                    byte_idx = 0;
                    xmit     = 1'b0;
                end else begin
                    stop_cnt++;
                    in_frame = 1'b0;
                end
            end else if (in_frame && !prev_scl && scl) begin
                if (bitn < 8)
                    shreg = {shreg[6:0], sda};
                else if (bitn == 8 && xmit)
                    mnack = sda;
                bitn++;
            end else if (in_frame && prev_scl && !scl) begin
                if (bitn == 8) begin
                    if (xmit) begin
                        pull = 1'b0;
                    end else if (byte_idx == 0) begin
                        rx_addr = shreg;
                        is_read = shreg[0];
                        pull    = ack_addr;
                    end else begin
                        rx_data = shreg;
                        pull    = ack_data;
                    end
                end else if (bitn == 9) begin
                    pull = 1'b0;
                    bitn = 0;
                    byte_idx++;
                    if (byte_idx == 1 && is_read && ack_addr) begin
                        xmit = 1'b1;
                        pull = ~tx[7];
                    end
                end else if (xmit && bitn >= 1 && bitn <= 7) begin
                    pull = ~tx[7-bitn];
                end
            end
            prev_scl = scl;
            prev_sda = sda;
        end
    end

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wd;
        logic       ack_a;
        logic       ack_d;
        logic [7:0] tx;
        logic       exp_err;
        logic [7:0] exp_rd;
        int         quarters;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic begin_txn(input vec_t v, output int t_acc);
        ack_addr = v.ack_a;
        ack_data = v.ack_d;
        tx       = v.tx;
        clr_seq++;
        @(negedge clk);
        #1;
        start    = 1'b1;
        dev_addr = v.addr;
        rw       = v.rw;
        wdata    = v.wd;
        @(negedge clk);
        start    = 1'b0;
        dev_addr = ~v.addr;
        wdata    = ~v.wd;
        #1;
        t_acc = cyc;
        chk("busy_after_accept", int'(busy), 1);
        chk("ack_err_cleared", int'(ack_err), 0);
    endtask

    task automatic do_txn(input vec_t v, input int poke, input string tag);
        int t_acc;
        int d0;
        int n;
        int lat;
        d0 = done_cnt;
        begin_txn(v, t_acc);
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
            if (poke > 0 && cyc - t_acc == poke) begin
                start    = 1'b1;
                dev_addr = 7'h01;
                rw       = 1'b0;
                wdata    = 8'h11;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL %s done_timeout act=none exp=done", tag);
        end else begin
            lat = done_cyc - t_acc;
            checks++;
            if (lat < v.quarters * CD || lat > v.quarters * CD + 3) begin
                errors++;
                $display("FAIL %s latency act=%0d exp=%0d", tag, lat, v.quarters * CD);
            end
        end
        repeat (6 * CD) @(negedge clk);
        #1;
        chk({tag, " done_pulses"}, done_cnt - d0, 1);
        chk({tag, " ack_err"}, int'(ack_err), int'(v.exp_err));
        chk({tag, " rdata"}, int'(rdata), int'(v.exp_rd));
        chk({tag, " busy_end"}, int'(busy), 0);
        chk({tag, " lines_released"}, int'({scl_oe, sda_oe}), 0);
        chk({tag, " addr_byte"}, int'(rx_addr), int'({v.addr, v.rw}));
        chk({tag, " starts"}, start_cnt, 1);
        chk({tag, " stops"}, stop_cnt, 1);
        chk({tag, " sda_while_scl_high"}, glitch_cnt, 2);
        if (!v.rw && v.ack_a)
            chk({tag, " data_byte"}, int'(rx_data), int'(v.wd));
        if (v.rw && v.ack_a)
            chk({tag, " master_nack"}, int'(mnack), 1);
    endtask

    vec_t vecs[7];
    vec_t t5v;
    vec_t t6v;

    initial begin : stim
        int t_acc;
        int n;
        reset_n  = 1'b0;
        start    = 1'b0;
        dev_addr = 7'h00;
        rw       = 1'b0;
        wdata    = 8'h00;

        vecs[0] = '{7'h45, 1'b0, 8'h45, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 80};
        vecs[1] = '{7'h45, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA3, 1'b0, 8'hA3, 80};
        vecs[2] = '{7'h47, 1'b0, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA3, 44};
        vecs[3] = '{7'h45, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA3, 80};
        vecs[4] = '{7'h45, 1'b1, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h5A, 80};
        vecs[5] = '{7'h47, 1'b1, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h5A, 44};
        vecs[6] = '{7'h40, 1'b0, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 8'h5A, 80};
        t5v     = '{7'h45, 1'b0, 8'h96, 1'b1, 1'b1, 8'h00, 1'b0, 8'h5A, 80};
        t6v     = '{7'h45, 1'b0, 8'h45, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 80};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_scl_oe", int'(scl_oe), 0);
        chk("rst_sda_oe", int'(sda_oe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ack_err", int'(ack_err), 0);
        chk("rst_rdata", int'(rdata), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++)
            do_txn(vecs[i], 0, $sformatf("vec%0d", i));

        do_txn(t5v, 100, "restart_ignored");

        // reset during the fourth address cell (quarter 16, SCL and SDA pulled)
        begin_txn(t6v, t_acc);
        n = 0;
        while (cyc - t_acc < 65 && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("pre_reset_scl_oe", int'(scl_oe), 1);
        chk("pre_reset_sda_oe", int'(sda_oe), 1);
        chk("pre_reset_busy", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_scl_oe", int'(scl_oe), 0);
        chk("async_rst_sda_oe", int'(sda_oe), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_rdata", int'(rdata), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        do_txn(t6v, 0, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
